// File: rtl/uart_hex_pkg.sv
// Shared state encodings and ASCII constants for the UART hex word printer.
package uart_hex_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        GAP   = 2'd2
    } state_e;

    localparam logic [7:0] ASCII_ZERO = 8'h30;
    localparam logic [7:0] ASCII_A    = 8'h41;
    localparam logic [7:0] ASCII_CR   = 8'h0D;
    localparam logic [7:0] ASCII_LF   = 8'h0A;

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Converts one nibble into its uppercase ASCII hex digit.
module hex_nibble_to_ascii
    import uart_hex_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = (nibble < 4'd10) ? (ASCII_ZERO + 8'(nibble))
                                 : (ASCII_A + 8'(nibble - 4'd10));
    end

endmodule

// File: rtl/uart_hex_sender.sv
// Prints a captured word as uppercase hex, MSB nibble first, then a line terminator.
// Define UART_HEX_SENDER_CRLF_EN to terminate with CR LF instead of LF alone.
module uart_hex_sender
    import uart_hex_pkg::*;
#(
    parameter int unsigned WORDW = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [WORDW-1:0] in_data,
    output logic             in_ready,
    input  logic             tx_ready,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic             busy
);

    localparam int unsigned NHEX  = WORDW / 4;
`ifdef UART_HEX_SENDER_CRLF_EN
    localparam int unsigned NTERM = 2;
`else
    localparam int unsigned NTERM = 1;
`endif
    localparam int unsigned NCHAR = NHEX + NTERM;
    localparam int unsigned IDXW  = $clog2(NCHAR);

    state_e           state_q, state_d;
    logic [IDXW-1:0]  idx_q, idx_d, sel_idx;
    logic [WORDW-1:0] word_q, word_d, src;
    logic [7:0]       tx_data_q, tx_data_d, hex_char, sel_char;
    logic [3:0]       nibble;

    // Character for the next index: from in_data on accept, else from the held word.
    always_comb begin
        src     = (state_q == IDLE) ? in_data : word_q;
        sel_idx = (state_q == IDLE) ? '0 : (idx_q + IDXW'(1));
        nibble  = 4'((src << {sel_idx, 2'b00}) >> (WORDW - 4));
        if (sel_idx < IDXW'(NHEX)) begin
            sel_char = hex_char;
        end else if ((NTERM == 2) && (sel_idx == IDXW'(NHEX))) begin
            sel_char = ASCII_CR;
        end else begin
            sel_char = ASCII_LF;
        end
    end

    hex_nibble_to_ascii u_nib (
        .nibble (nibble),
        .ascii  (hex_char)
    );

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        word_d    = word_q;
        tx_data_d = tx_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    word_d    = in_data;
                    idx_d     = '0;
                    tx_data_d = sel_char;
                    state_d   = ISSUE;
                end
            end
            ISSUE: begin
                if (tx_ready) begin
                    state_d = GAP;
                end
            end
            GAP: begin
                // Single-cycle gap lets the transmitter drop tx_ready before we look again.
                if (idx_q == IDXW'(NCHAR - 1)) begin
                    idx_d   = '0;
                    state_d = IDLE;
                end else begin
                    idx_d     = sel_idx;
                    tx_data_d = sel_char;
                    state_d   = ISSUE;
                end
            end
            default: begin
                state_d = IDLE;
                idx_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= IDLE;
            idx_q     <= '0;
            word_q    <= '0;
            tx_data_q <= 8'h00;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            word_q    <= word_d;
            tx_data_q <= tx_data_d;
        end
    end

    assign in_ready = (state_q == IDLE);
    assign busy     = (state_q != IDLE);
    assign tx_start = (state_q == ISSUE) && tx_ready;
    assign tx_data  = tx_data_q;

endmodule

// File: doc/uart_hex_sender.md
UART_HEX_SENDER -- requirements
Module: uart_hex_sender

Interface
REQ-001 The block SHALL have parameter WORDW, default 32, giving the input word width in bits; it must be a multiple of 4 and at least 4.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state is updated on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is asynchronous and active-low.
REQ-004 The block SHALL have port in_valid, input, 1 bit: the upstream word is valid.
REQ-005 The block SHALL have port in_data, input, WORDW bits: the word to print.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept a word.
REQ-007 The block SHALL have port tx_ready, input, 1 bit: the downstream byte transmitter is idle.
REQ-008 The block SHALL have port tx_start, output, 1 bit: a one-cycle byte launch strobe to the transmitter.
REQ-009 The block SHALL have port tx_data, output, 8 bits: the ASCII byte that goes with tx_start.
REQ-010 The block SHALL have port busy, output, 1 bit: a word is being emitted.

Function
REQ-011 The block SHALL accept a word on a cycle where in_valid and in_ready are both high, capturing in_data into an internal register.
REQ-012 The block SHALL drive in_ready high only in state IDLE; busy SHALL be the inverse of in_ready.
REQ-013 The block SHALL emit WORDW/4 hex characters, most significant nibble first, followed by a terminator.
REQ-014 Nibble encoding SHALL be: 0-9 maps to 0x30-0x39 and A-F maps to 0x41-0x46 (uppercase).
REQ-015 The state machine SHALL have states IDLE, ISSUE and GAP: IDLE goes to ISSUE on accept; ISSUE goes to GAP when tx_ready=1; GAP goes to ISSUE when characters remain, or to IDLE after the last character.
REQ-016 tx_start SHALL be combinational (state==ISSUE and tx_ready), high for exactly one cycle per character.
REQ-017 tx_data SHALL be valid whenever tx_start is high and SHALL hold stable through GAP.
REQ-018 GAP SHALL last exactly one cycle, so that tx_ready (which falls one cycle after start) is not resampled stale.
REQ-019 While in ISSUE with tx_ready=0, the block SHALL wait indefinitely with tx_start=0.
REQ-020 Latency: for an accept at cycle N with tx_ready held high, the first tx_start SHALL occur at cycle N+1.
REQ-021 The character index counter SHALL be $clog2 of the total character count wide, and SHALL clear on return to IDLE.
REQ-022 in_valid SHALL be ignored while busy, and no word SHALL be queued.
REQ-023 A new word SHALL be acceptable in the cycle after GAP returns the block to IDLE.

Reset
REQ-024 While reset=0, the block SHALL asynchronously force state=IDLE, index=0, word register=0, tx_start=0, tx_data=0x00, in_ready=1 and busy=0.
REQ-025 Reset asserted mid-word SHALL abandon the remaining characters with no further tx_start; a byte already in flight downstream is not this block's concern.

Configuration
REQ-026 When UART_HEX_SENDER_CRLF_EN is defined, the terminator SHALL be 0x0D 0x0A, giving a total of WORDW/4+2 characters.
REQ-027 When UART_HEX_SENDER_CRLF_EN is undefined, the terminator SHALL be 0x0A only, giving a total of WORDW/4+1 characters.

Structure
REQ-028 Package uart_hex_pkg SHALL hold the state encodings (IDLE, ISSUE, GAP) and the ASCII constants (0x30, 0x41, 0x0D, 0x0A).
REQ-029 The block SHALL use one combinational sub-module, hex_nibble_to_ascii (4-bit nibble in, 8-bit byte out).
REQ-030 tx_start, tx_data and tx_ready SHALL connect directly to the start, data and ready ports of the byte transmitter.

Verification
REQ-031 Accept 0xDEADBEEF with tx_ready modelled by a transmitter model: the bytes SHALL be 44 45 41 44 42 45 45 46 0A, or with the macro defined 44 45 41 44 42 45 45 46 0D 0A.
REQ-032 Hold tx_ready=0 for 50 cycles after accept: tx_start SHALL stay 0 and in_ready SHALL stay 0; raising tx_ready SHALL give a tx_start on the same cycle with tx_data=0x44.
REQ-033 Pulse in_valid with 0x12345678 while busy: it SHALL be ignored, and the output SHALL remain the prior word's characters only.
REQ-034 Assert reset after the 3rd character of 0x0000FFFF: there SHALL be no tx_start after reset, in_ready=1, and the next accepted word 0x00000001 SHALL print as 30 30 30 30 30 30 30 31 plus the terminator.
REQ-035 Send two back-to-back words with in_valid held high: the second accept SHALL occur exactly one cycle after the final GAP, and there SHALL be exactly one tx_start per character.
REQ-036 For WORDW=8, input 0xA5 SHALL give 41 35 plus the terminator.
